// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select and load-use stall generation
// Tracks in-flight writers in a shift register of pipeline slots (slot 1 is
// the instruction immediately older than the consumer at the select point).
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   id_valid_ip      - consumer is a real instruction
//   id_rs_ip         - NUM_SRC packed 5-bit source indices, operand i at [5i+4:5i]
//   id_rs_used_ip    - per-operand read mask
//   id_rd_ip         - consumer destination register
//   id_wb_kind_ip    - consumer writeback kind: 0 none, 1 ALU, 2 load, 3 none
//   flush_ip         - kill the consumer this cycle
//   fwd_sel_op       - per-operand select: 0 register file, k forward from slot k
//   stall_op         - hold consumer and upstream this cycle
//   stall_cnt_op     - saturating count of stall cycles
module fwd_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    localparam int SW        = $clog2(FWD_STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid_ip,
    input  logic [NUM_SRC*5-1:0]    id_rs_ip,
    input  logic [NUM_SRC-1:0]      id_rs_used_ip,
    input  logic [4:0]              id_rd_ip,
    input  logic [1:0]              id_wb_kind_ip,
    input  logic                    flush_ip,
    output logic [NUM_SRC*SW-1:0]   fwd_sel_op,
    output logic                    stall_op,
    output logic [CNT_W-1:0]        stall_cnt_op
);
    localparam logic [1:0] K_NONE = 2'd0, K_ALU = 2'd1, K_LOAD = 2'd2;
    logic [FWD_STAGES:1]   r_vld;
    logic [4:0]            r_rd   [1:FWD_STAGES];
    logic [1:0]            r_kind [1:FWD_STAGES];
    logic [CNT_W-1:0]      r_cnt;
    logic [SW-1:0]         w_win  [NUM_SRC];
    logic [1:0]            w_wkind[NUM_SRC];
    logic [NUM_SRC-1:0]    w_haz;
    logic [NUM_SRC*SW-1:0] w_sel;
    logic [1:0]            w_kind_in;
    logic                  w_stall;
    // Scanning oldest to youngest lets the youngest match overwrite older ones;
    // a not-yet-ready youngest match stalls rather than falling back to an older slot.
    always_comb begin
        w_sel = '0;
        w_haz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_win[i]   = '0;
            w_wkind[i] = K_NONE;
            for (int k = FWD_STAGES; k >= 1; k--)
                if (r_vld[k] && r_kind[k] != K_NONE && r_rd[k] == id_rs_ip[5*i +: 5]) begin
                    w_win[i]   = SW'(k);
                    w_wkind[i] = r_kind[k];
                end
            if (id_valid_ip && id_rs_used_ip[i] && id_rs_ip[5*i +: 5] != 5'd0 && w_win[i] != '0) begin
                if (int'(w_win[i]) >= (w_wkind[i] == K_LOAD ? LOAD_READY : ALU_READY))
                    w_sel[SW*i +: SW] = w_win[i];
                else
                    w_haz[i] = 1'b1;
            end
        end
    end
    // A writer to x0 never produces a forwardable value; reserved kind is ignored.
    assign w_kind_in    = (id_rd_ip == 5'd0 || id_wb_kind_ip == 2'd3) ? K_NONE : id_wb_kind_ip;
    assign w_stall      = (|w_haz) && !flush_ip && !reset;
    assign stall_op     = w_stall;
    assign fwd_sel_op   = reset ? '0 : w_sel;
    assign stall_cnt_op = r_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            r_cnt <= '0;
        end else begin
            for (int k = FWD_STAGES; k >= 2; k--) begin
                r_vld[k]  <= r_vld[k-1];
                r_rd[k]   <= r_rd[k-1];
                r_kind[k] <= r_kind[k-1];
            end
            r_vld[1]  <= id_valid_ip && !w_stall && !flush_ip;
            r_rd[1]   <= id_rd_ip;
            r_kind[1] <= w_kind_in;
            if (w_stall && r_cnt != '1)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the ID/EX forwarding-select logic.
- Tracks every in-flight register writer in an internal shift register of pipeline slots, and issues a per-operand forwarding select for NUM_SRC source operands.
- Detects load-use hazards and holds the consumer (stall plus bubble insertion) until the load data can be forwarded.
- Sits beside the ID/EX buffer. Its select outputs drive the operand forwarding muxes. Its stall output gates the PC/IF/ID enables.

Parameters:
- NUM_SRC, 2: number of source operands checked per consumer (1..3).
- FWD_STAGES, 3: number of tracked older pipeline slots that can forward (1..6).
- ALU_READY, 1: first slot index in which an ALU result is forwardable.
- LOAD_READY, 2: first slot index in which load data is forwardable (ALU_READY <= LOAD_READY <= FWD_STAGES).
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- id_valid_ip, input, 1: the consumer at the operand-select point is a real instruction.
- id_rs_ip, input, NUM_SRC*5: source register indices; operand i is at bits [5i+4:5i].
- id_rs_used_ip, input, NUM_SRC: per-operand "operand is read" mask.
- id_rd_ip, input, 5: consumer destination register.
- id_wb_kind_ip, input, 2: consumer writeback kind. 0 = NONE, 1 = ALU, 2 = LOAD, 3 = reserved (treated as NONE).
- flush_ip, input, 1: kill the consumer this cycle.
- fwd_sel_op, output, NUM_SRC*SW where SW = $clog2(FWD_STAGES+1): per-operand select. 0 = ORIGINAL (register file); k = forward from slot k.
- stall_op, output, 1: hold consumer and upstream this cycle.
- stall_cnt_op, output, CNT_W: saturating count of stall cycles.

Behaviour:
- State:
  - slot[1..FWD_STAGES], each holding {valid, rd, kind}. Slot 1 is the instruction immediately older than the consumer.
  - stall_cnt register.
- Reset (synchronous, clk edge with reset=1):
  - All slot.valid = 0; stall_cnt = 0.
  - While reset is high, stall_op = 0 and fwd_sel_op = 0 regardless of inputs.
  - A reset asserted mid-stall drops the stall on the next cycle. No pending state survives.
- Match rule, evaluated combinationally each cycle for each operand i:
  - Applies only if id_valid_ip=1, id_rs_used_ip[i]=1 and rs_i != 0.
  - Candidate slots: valid, kind != NONE, rd == rs_i.
  - The lowest-index (youngest) candidate k wins. Older candidates are ignored even if ready.
  - No candidate gives sel = 0.
- Readiness of winning slot k:
  - kind ALU is ready iff k >= ALU_READY.
  - kind LOAD is ready iff k >= LOAD_READY.
  - Ready gives sel_i = k. Not ready gives sel_i = 0 and raises hazard_i.
- stall_op = OR(hazard_i) AND NOT flush_ip AND NOT reset. It is combinational, with no added latency.
- Slot update on every clk edge (not in reset):
  - slot[k+1] <= slot[k] for k = 1..FWD_STAGES-1. The oldest slot's contents retire.
  - slot[1] loads the consumer {1, id_rd_ip, kind} only if id_valid_ip=1, stall_op=0 and flush_ip=0.
  - Otherwise slot[1] becomes a bubble (valid=0).
  - A consumer with rd=0 is loaded with kind forced to NONE.
- Stall duration: a load at slot j blocks for LOAD_READY-j cycles. With the defaults, a back-to-back load-use costs exactly 1 stall cycle.
- Flush: takes priority over stall. The consumer is not tracked, stall_op=0, and older slots still advance.
- Operand independence:
  - Operands may each forward from different slots, or the same slot, in the same cycle.
  - If any operand stalls, fwd_sel_op values are still driven but are don't-care to consumers.
- stall_cnt increments by 1 on each edge where stall_op=1. It saturates at all-ones and never wraps.
- Beyond slot FWD_STAGES, results are in the register file (write-through). The unit does not track them.

Test Plan:
- ALU chain: producer ALU rd=5, next consumer rs1=5, rs2=5 → fwd_sel both = 1, stall_op=0. Two cycles later, a consumer reading rs1=5 gets sel=2 with no stall.
- Load-use: LOAD rd=7 followed immediately by consumer rs2=7 → stall_op=1 for exactly 1 cycle, slot 1 gets a bubble. Next cycle sel_rs2=2, stall_op=0, stall_cnt=1.
- Youngest wins: ALU rd=3 in slot 2 and ALU rd=3 in slot 1 → sel=1. LOAD rd=3 in slot 1 over a ready ALU rd=3 in slot 2 → stall (no fallback to slot 2).
- x0 and unused operands: rs1=0 with producer rd=0, and rs2=9 with id_rs_used_ip[1]=0 and a LOAD rd=9 in slot 1 → both sel=0, stall_op=0.
- Flush and reset:
  - Load-use hazard with flush_ip=1 → stall_op=0, consumer not tracked (slot 1 bubble next cycle).
  - Reset asserted during a stall → next cycle all sel=0, stall_op=0, stall_cnt=0.
- Saturation and parameters: with CNT_W=4, force 20 stall cycles → stall_cnt_op = 15. Rerun the load-use case with LOAD_READY=3 and FWD_STAGES=4 → 2 stall cycles, then sel=3.
